// File: rtl/mem_stage_pkg.sv
// Shared RV32I pipeline types used by the MEM stage and its alignment helper.
// Defining MEM_STAGE_RVFI_EN adds access-trace fields to mem_wb_t.
package rv32i_types;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    rf_alu_out,
    rf_br_en,
    rf_u_imm,
    rf_load,
    rf_pc_plus4
  } regfilemux_sel_t;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  localparam logic [2:0] f3_lb  = 3'b000;
  localparam logic [2:0] f3_lh  = 3'b001;
  localparam logic [2:0] f3_lw  = 3'b010;
  localparam logic [2:0] f3_lbu = 3'b100;
  localparam logic [2:0] f3_lhu = 3'b101;
  localparam logic [2:0] f3_sb  = 3'b000;
  localparam logic [2:0] f3_sh  = 3'b001;
  localparam logic [2:0] f3_sw  = 3'b010;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [31:0]     rs1_v;
    logic [31:0]     rs2_v;
    logic [31:0]     aluout;
    logic [31:0]     u_imm;
    logic            br_en;
    regfilemux_sel_t regfilemux_sel;
    logic            regf_we;
    logic            commit;
  } ex_mem_t;

`ifdef MEM_STAGE_RVFI_EN
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic        regf_we;
    logic [31:0] rd_v;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mem_wb_t;
`else
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic        regf_we;
    logic [31:0] rd_v;
  } mem_wb_t;
`endif

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane masks, store-data shifting and load-data extraction/extension.
// Purely combinational; used once for request issue and once for load return.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [3:0]  mask;
  logic [15:0] shifted;

  always_comb begin
    case (funct3[1:0])
      2'b00:   mask = 4'b0001 << off;
      2'b01:   mask = 4'b0011 << off;
      default: mask = 4'b1111;
    endcase
  end

  assign rmask = is_load  ? mask : 4'b0000;
  assign wmask = is_store ? mask : 4'b0000;
  assign wdata = (funct3[1:0] == 2'b10) ? store_data : (store_data << {off, 3'b000});

  // Only the low half of the lane-shifted word is ever needed; lw bypasses it.
  assign shifted = 16'(load_word >> {off, 3'b000});

  always_comb begin
    case (funct3)
      f3_lb:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      f3_lh:   load_data = {{16{shifted[15]}}, shifted};
      f3_lbu:  load_data = {24'h0, shifted[7:0]};
      f3_lhu:  load_data = {16'h0, shifted};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM pipeline stage with an IDLE/WAIT data-memory handshake.
// Optional MEM_STAGE_RVFI_EN records the completed access in mem_wb.
module mem_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_t     ex_mem,
  output mem_wb_t     mem_wb,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic        mem_forward_br_en,
  output logic [31:0] mem_forward_alu_out,
  output logic [31:0] mem_forward_u_imm
);

  mem_state_t  state, next_state;
  logic        mem_op, issue, access;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_rmask, cap_wmask;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_off;
  logic [3:0]  iss_rmask, iss_wmask;
  logic [31:0] iss_wdata, iss_load;
  logic [3:0]  ret_rmask, ret_wmask;
  logic [31:0] ret_wdata, ret_load;
  logic        unused_ret;
  logic [31:0] load_data, rd_v;
  mem_wb_t     wb_next;

  assign mem_op = ex_mem.commit &&
                  (ex_mem.opcode == op_b_load || ex_mem.opcode == op_b_store);
  assign issue  = (state == IDLE) && mem_op;
  assign access = issue || (state == WAIT);
  assign mem_stall = access && !dmem_resp;

  assign mem_forward_br_en   = ex_mem.br_en;
  assign mem_forward_alu_out = ex_mem.aluout;
  assign mem_forward_u_imm   = ex_mem.u_imm;

  mem_align u_issue_align (
    .funct3     (ex_mem.funct3),
    .off        (ex_mem.aluout[1:0]),
    .is_load    (ex_mem.opcode == op_b_load),
    .is_store   (ex_mem.opcode == op_b_store),
    .store_data (ex_mem.rs2_v),
    .load_word  (dmem_rdata),
    .rmask      (iss_rmask),
    .wmask      (iss_wmask),
    .wdata      (iss_wdata),
    .load_data  (iss_load)
  );

  // Return path extracts load data using the access parameters latched at issue.
  mem_align u_return_align (
    .funct3     (cap_funct3),
    .off        (cap_off),
    .is_load    (1'b1),
    .is_store   (1'b0),
    .store_data (cap_wdata),
    .load_word  (dmem_rdata),
    .rmask      (ret_rmask),
    .wmask      (ret_wmask),
    .wdata      (ret_wdata),
    .load_data  (ret_load)
  );

  assign unused_ret = ^{ret_rmask, ret_wmask, ret_wdata};

  always_comb begin
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    if (state == WAIT) begin
      dmem_addr  = cap_addr;
      dmem_rmask = cap_rmask;
      dmem_wmask = cap_wmask;
      dmem_wdata = cap_wdata;
    end else if (mem_op) begin
      dmem_addr  = {ex_mem.aluout[31:2], 2'b00};
      dmem_rmask = iss_rmask;
      dmem_wmask = iss_wmask;
      dmem_wdata = iss_wdata;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_op && !dmem_resp) next_state = WAIT;
      WAIT:    if (dmem_resp) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr   <= '0;
      cap_rmask  <= '0;
      cap_wmask  <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= '0;
      cap_off    <= '0;
    end else if (issue && !dmem_resp) begin
      cap_addr   <= {ex_mem.aluout[31:2], 2'b00};
      cap_rmask  <= iss_rmask;
      cap_wmask  <= iss_wmask;
      cap_wdata  <= iss_wdata;
      cap_funct3 <= ex_mem.funct3;
      cap_off    <= ex_mem.aluout[1:0];
    end
  end

  assign load_data = (state == WAIT) ? ret_load : iss_load;

  always_comb begin
    case (ex_mem.regfilemux_sel)
      rf_alu_out:  rd_v = ex_mem.aluout;
      rf_br_en:    rd_v = {31'b0, ex_mem.br_en};
      rf_u_imm:    rd_v = ex_mem.u_imm;
      rf_load:     rd_v = load_data;
      rf_pc_plus4: rd_v = ex_mem.pc + 32'd4;
      default:     rd_v = ex_mem.aluout;
    endcase
  end

  // A stalled cycle retires a bubble so WB never sees a half-finished access.
  always_comb begin
    wb_next = '0;
    if (!mem_stall) begin
      wb_next.valid   = ex_mem.commit;
      wb_next.pc      = ex_mem.pc;
      wb_next.inst    = ex_mem.inst;
      wb_next.rd_s    = ex_mem.rd_s;
      wb_next.rs1_s   = ex_mem.rs1_s;
      wb_next.rs2_s   = ex_mem.rs2_s;
      wb_next.rs1_v   = ex_mem.rs1_v;
      wb_next.rs2_v   = ex_mem.rs2_v;
      wb_next.regf_we = ex_mem.commit && ex_mem.regf_we;
      wb_next.rd_v    = rd_v;
`ifdef MEM_STAGE_RVFI_EN
      if (access) begin
        wb_next.mem_addr  = dmem_addr;
        wb_next.mem_rmask = dmem_rmask;
        wb_next.mem_wmask = dmem_wmask;
        wb_next.mem_rdata = dmem_rdata;
        wb_next.mem_wdata = dmem_wdata;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wb <= '0;
    end else begin
      mem_wb <= wb_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage; expected write-back words go into a
// scoreboard queue that a separate monitor drains whenever mem_wb.valid is seen.
module tb_mem_stage;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_stall;
  logic        mem_forward_br_en;
  logic [31:0] mem_forward_alu_out;
  logic [31:0] mem_forward_u_imm;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rd_v;
    logic        we;
    int          cycle;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  mem_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_mem              (ex_mem),
    .mem_wb              (mem_wb),
    .dmem_addr           (dmem_addr),
    .dmem_rmask          (dmem_rmask),
    .dmem_wmask          (dmem_wmask),
    .dmem_wdata          (dmem_wdata),
    .dmem_rdata          (dmem_rdata),
    .dmem_resp           (dmem_resp),
    .mem_stall           (mem_stall),
    .mem_forward_br_en   (mem_forward_br_en),
    .mem_forward_alu_out (mem_forward_alu_out),
    .mem_forward_u_imm   (mem_forward_u_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  function automatic ex_mem_t mk_em(input rv32i_opcode op, input logic [2:0] f3,
                                    input logic [31:0] alu, input logic [31:0] rs2v,
                                    input regfilemux_sel_t sel, input logic we,
                                    input logic commit, input logic [31:0] pc);
    ex_mem_t e;
    e = '0;
    e.pc             = pc;
    e.inst           = {22'h0, f3, op};
    e.opcode         = op;
    e.funct3         = f3;
    e.rd_s           = 5'd5;
    e.rs1_s          = 5'd1;
    e.rs2_s          = 5'd2;
    e.rs1_v          = 32'h1111_1111;
    e.rs2_v          = rs2v;
    e.aluout         = alu;
    e.u_imm          = 32'hABCD_E000;
    e.br_en          = 1'b1;
    e.regfilemux_sel = sel;
    e.regf_we        = we;
    e.commit         = commit;
    return e;
  endfunction

  // Holds one EX/MEM word for as long as a real pipeline would (frozen while stalled).
  task automatic applyStimulus(input ex_mem_t em, input int delay, input logic [31:0] rdata,
                               input logic stray, input logic [31:0] e_addr,
                               input logic [3:0] e_rmask, input logic [3:0] e_wmask,
                               input logic [31:0] e_wdata, input logic [31:0] e_rd_v);
    bit   is_mem;
    int   d;
    exp_t x;
    is_mem = em.commit && (em.opcode == op_b_load || em.opcode == op_b_store);
    d = is_mem ? delay : 0;
    ex_mem     = em;
    dmem_rdata = rdata;
    dmem_resp  = is_mem ? (d == 0) : stray;
    if (em.commit) begin
      x.pc    = em.pc;
      x.rd_v  = e_rd_v;
      x.we    = em.regf_we;
      x.cycle = cyc + d + 1;
      sb_q.push_back(x);
    end
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      checkOutput("mem_stall", {31'b0, mem_stall}, {31'b0, (is_mem && i < d)});
      checkOutput("dmem_rmask", {28'b0, dmem_rmask}, {28'b0, e_rmask});
      checkOutput("dmem_wmask", {28'b0, dmem_wmask}, {28'b0, e_wmask});
      if (is_mem) checkOutput("dmem_addr", dmem_addr, e_addr);
      if (e_wmask != 4'b0000) checkOutput("dmem_wdata", dmem_wdata, e_wdata);
      if (i == 0) checkOutput("fwd_alu_out", mem_forward_alu_out, em.aluout);
      @(posedge clk);
      #1;
      dmem_resp = is_mem && (i + 1 == d);
    end
  endtask

  task automatic resetMidWait();
    ex_mem    = mk_em(op_b_load, f3_lw, 32'h0000_7000, 32'h0, rf_load, 1'b1, 1'b1, 32'h200);
    dmem_resp = 1'b0;
    @(negedge clk);
    checkOutput("rw_issue_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rw_wait_rmask", {28'b0, dmem_rmask}, 32'hF);
    rst    = 1'b0;
    ex_mem = mk_em(op_b_imm, 3'b000, 32'h0, 32'h0, rf_alu_out, 1'b1, 1'b0, 32'h204);
    #1;
    checkOutput("rw_rst_rmask", {28'b0, dmem_rmask}, 32'h0);
    checkOutput("rw_rst_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("rw_rst_valid", {31'b0, mem_wb.valid}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst       = 1'b1;
    dmem_resp = 1'b1;
    #1;
    checkOutput("rw_stray_rmask", {28'b0, dmem_rmask}, 32'h0);
    checkOutput("rw_stray_wmask", {28'b0, dmem_wmask}, 32'h0);
    checkOutput("rw_stray_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    checkOutput("rw_after_valid", {31'b0, mem_wb.valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid write-back word must match the oldest expectation, on time.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst && mem_wb.valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wb: got valid word pc 0x%08h, expected no output",
                   mem_wb.pc);
        end else begin
          x = sb_q.pop_front();
          checkOutput("wb_cycle", cyc, x.cycle);
          checkOutput("wb_pc", mem_wb.pc, x.pc);
          checkOutput("wb_rd_v", mem_wb.rd_v, x.rd_v);
          checkOutput("wb_regf_we", {31'b0, mem_wb.regf_we}, {31'b0, x.we});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst        = 1'b0;
    ex_mem     = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {31'b0, mem_wb.valid}, 32'd0);
    checkOutput("rst_rd_v", mem_wb.rd_v, 32'h0);
    checkOutput("rst_rmask", {28'b0, dmem_rmask}, 32'h0);
    checkOutput("rst_wmask", {28'b0, dmem_wmask}, 32'h0);
    checkOutput("rst_stall", {31'b0, mem_stall}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(mk_em(op_b_reg, 3'b000, 32'h0000_0055, 32'h0, rf_alu_out, 1'b1, 1'b1, 32'h100),
                  0, 32'h0, 1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0000_0055);
    checkOutput("fwd_br_en", {31'b0, mem_forward_br_en}, 32'd1);
    checkOutput("fwd_u_imm", mem_forward_u_imm, 32'hABCD_E000);
    applyStimulus(mk_em(op_b_load, f3_lw, 32'h1000_0006, 32'h0, rf_load, 1'b1, 1'b1, 32'h104),
                  2, 32'h1234_5678, 1'b0, 32'h1000_0004, 4'hF, 4'h0, 32'h0, 32'h1234_5678);
    applyStimulus(mk_em(op_b_load, f3_lw, 32'h0000_2000, 32'h0, rf_load, 1'b1, 1'b0, 32'h108),
                  0, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
    applyStimulus(mk_em(op_b_load, f3_lb, 32'h0000_2003, 32'h0, rf_load, 1'b1, 1'b1, 32'h10C),
                  0, 32'h80AB_CDEF, 1'b0, 32'h0000_2000, 4'b1000, 4'h0, 32'h0, 32'hFFFF_FF80);
    applyStimulus(mk_em(op_b_load, f3_lbu, 32'h0000_2003, 32'h0, rf_load, 1'b1, 1'b1, 32'h110),
                  0, 32'h80AB_CDEF, 1'b0, 32'h0000_2000, 4'b1000, 4'h0, 32'h0, 32'h0000_0080);
    applyStimulus(mk_em(op_b_store, f3_sh, 32'h0000_3002, 32'h0000_BEEF, rf_alu_out, 1'b0, 1'b1, 32'h114),
                  0, 32'h0, 1'b0, 32'h0000_3000, 4'h0, 4'b1100, 32'hBEEF_0000, 32'h0000_3002);
    applyStimulus(mk_em(op_b_store, f3_sw, 32'h0000_4000, 32'hDEAD_BEEF, rf_alu_out, 1'b0, 1'b1, 32'h118),
                  1, 32'h0, 1'b0, 32'h0000_4000, 4'h0, 4'hF, 32'hDEAD_BEEF, 32'h0000_4000);
    applyStimulus(mk_em(op_b_load, f3_lw, 32'h0000_4000, 32'h0, rf_load, 1'b1, 1'b1, 32'h11C),
                  1, 32'hCAFE_F00D, 1'b0, 32'h0000_4000, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D);
    applyStimulus(mk_em(op_b_load, f3_lh, 32'h0000_5002, 32'h0, rf_load, 1'b1, 1'b1, 32'h120),
                  1, 32'h8001_1234, 1'b0, 32'h0000_5000, 4'b1100, 4'h0, 32'h0, 32'hFFFF_8001);
    applyStimulus(mk_em(op_b_load, f3_lhu, 32'h0000_5002, 32'h0, rf_load, 1'b1, 1'b1, 32'h124),
                  0, 32'h8001_1234, 1'b0, 32'h0000_5000, 4'b1100, 4'h0, 32'h0, 32'h0000_8001);
    applyStimulus(mk_em(op_b_store, f3_sb, 32'h0000_6001, 32'h0000_00A5, rf_alu_out, 1'b0, 1'b1, 32'h128),
                  0, 32'h0, 1'b0, 32'h0000_6000, 4'h0, 4'b0010, 32'h0000_A500, 32'h0000_6001);
    applyStimulus(mk_em(op_b_jal, 3'b000, 32'h0000_9999, 32'h0, rf_pc_plus4, 1'b1, 1'b1, 32'hFFFF_FFFC),
                  0, 32'h0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0000_0000);
    applyStimulus(mk_em(op_b_reg, 3'b000, 32'h0, 32'h0, rf_br_en, 1'b1, 1'b1, 32'h130),
                  0, 32'h0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0000_0001);
    applyStimulus(mk_em(op_b_lui, 3'b000, 32'h0, 32'h0, rf_u_imm, 1'b1, 1'b1, 32'h134),
                  0, 32'h0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'hABCD_E000);
    applyStimulus(mk_em(op_b_imm, 3'b000, 32'h0, 32'h0, rf_alu_out, 1'b1, 1'b0, 32'h138),
                  0, 32'h0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);

    resetMidWait();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
